// File: rtl/gc_mem_pkg.sv
// gc_mem_pkg: sweep FSM state type and default geometry for the gain-cell bank
package gc_mem_pkg;
  typedef enum logic [1:0] {
    SR_IDLE  = 2'd0,
    SR_SWEEP = 2'd1,
    SR_DONE  = 2'd2
  } sr_state_t;
  localparam int DATA_W_DEF        = 64;
  localparam int DEPTH_DEF         = 128;
  localparam int RETENTION_CYC_DEF = 4096;
endpackage

// File: rtl/gc_sr_sweeper.sv
// gc_sr_sweeper: self-refresh sequencer, row walker and retention timer
module gc_sr_sweeper
  import gc_mem_pkg::*;
#(
  parameter int DEPTH         = DEPTH_DEF,
  parameter int RETENTION_CYC = RETENTION_CYC_DEF,
  parameter int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sr,
  input  logic              u_re,
  output logic [ADDR_W-1:0] row,
  output logic              emit,
  output logic              busy,
  output logic              sr_req,
  output logic              ref_done
);
  localparam int CNT_W = $clog2(RETENTION_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] RET_MAX = CNT_W'(RETENTION_CYC - 1);
  sr_state_t state;
  logic [CNT_W-1:0] ret_cnt;
  // a user read owns the single read port, so the sweep stalls that cycle
  assign emit   = state == SR_SWEEP && !u_re;
  assign busy   = state != SR_IDLE;
  assign sr_req = state == SR_IDLE && ret_cnt == RET_MAX;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= SR_IDLE;
      row      <= '0;
      ret_cnt  <= '0;
      ref_done <= 1'b0;
    end else begin
      ref_done <= state == SR_DONE;
      if (state == SR_IDLE) begin
        if (ret_cnt != RET_MAX) ret_cnt <= ret_cnt + 1'b1;
        if (start_sr) begin
          state <= SR_SWEEP;
          row   <= '0;
        end
      end else if (state == SR_SWEEP) begin
        if (emit) row <= row + 1'b1;
        if (emit && row == LAST) state <= SR_DONE;
      end else begin
        state   <= SR_IDLE;
        ret_cnt <= '0;
      end
    end
endmodule

// File: rtl/gc_mem_bank.sv
// gc_mem_bank: gain-cell DRAM bank with user port, refresh-chain input and self-refresh sweep output
module gc_mem_bank
  import gc_mem_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int RETENTION_CYC = RETENTION_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              u_we,
  input  logic [ADDR_W-1:0] u_write_addr,
  input  logic [DATA_W-1:0] u_data_in,
  input  logic              u_re,
  input  logic [ADDR_W-1:0] u_read_addr,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  input  logic              ref_en_in,
  input  logic [ADDR_W-1:0] ref_addr_in,
  input  logic [DATA_W-1:0] ref_data_in,
  input  logic              start_sr,
  output logic              sr_req,
  output logic              sr_busy,
  output logic              sr_valid_out,
  output logic [ADDR_W-1:0] sr_addr_out,
  output logic [DATA_W-1:0] sr_data_out,
  output logic              ref_done
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] row, ra;
  logic [DATA_W-1:0] rdata;
  logic emit, ref_wr;
  gc_sr_sweeper #(.DEPTH(DEPTH), .RETENTION_CYC(RETENTION_CYC), .ADDR_W(ADDR_W)) u_sweeper (
    .clk(clk), .rst(rst), .start_sr(start_sr), .u_re(u_re), .row(row),
    .emit(emit), .busy(sr_busy), .sr_req(sr_req), .ref_done(ref_done)
  );
  assign ref_wr = ref_en_in && !(u_we && u_write_addr == ref_addr_in);
  assign ra     = u_re ? u_read_addr : row;
  // write-first bypass, user data taking precedence over refresh data
  assign rdata  = (u_we && u_write_addr == ra) ? u_data_in :
                  (ref_en_in && ref_addr_in == ra) ? ref_data_in : mem[ra];
  always_ff @(posedge clk) begin
    if (u_we) mem[u_write_addr] <= u_data_in;
    if (ref_wr) mem[ref_addr_in] <= ref_data_in;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd           <= '0;
      rd_valid     <= 1'b0;
      sr_valid_out <= 1'b0;
      sr_addr_out  <= '0;
      sr_data_out  <= '0;
    end else begin
      rd_valid     <= u_re;
      sr_valid_out <= emit;
      if (u_re) rd <= rdata;
      if (emit) begin
        sr_addr_out <= row;
        sr_data_out <= rdata;
      end
    end
endmodule

// File: tb/tb_gc_mem_bank.sv
// tb_gc_mem_bank: vector table plus scoreboarded read and sweep streams for gc_mem_bank
module tb_gc_mem_bank;
  logic clk, rst;
  logic u_we, u_re, ref_en_in, start_sr;
  logic [6:0] u_write_addr, u_read_addr, ref_addr_in;
  logic [63:0] u_data_in, ref_data_in;
  logic [63:0] rd, sr_data_out;
  logic rd_valid, sr_req, sr_busy, sr_valid_out, ref_done;
  logic [6:0] sr_addr_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic [6:0]  a;
    logic [63:0] d;
  } sw_t;
  typedef struct {
    logic        we;
    logic [6:0]  wa;
    logic [63:0] wd;
    logic        re;
    logic [6:0]  ra;
    logic        ren;
    logic [6:0]  refa;
    logic [63:0] refd;
    logic [63:0] exp;
  } vec_t;
  logic [63:0] model [128];
  logic [63:0] rd_q [$];
  sw_t sw_q [$];
  sw_t mon_e;
  vec_t tv [15];
  int n, cnt;

  gc_mem_bank #(.DATA_W(64), .DEPTH(128), .RETENTION_CYC(16)) dut (
    .clk(clk), .rst(rst), .u_we(u_we), .u_write_addr(u_write_addr), .u_data_in(u_data_in),
    .u_re(u_re), .u_read_addr(u_read_addr), .rd(rd), .rd_valid(rd_valid),
    .ref_en_in(ref_en_in), .ref_addr_in(ref_addr_in), .ref_data_in(ref_data_in),
    .start_sr(start_sr), .sr_req(sr_req), .sr_busy(sr_busy), .sr_valid_out(sr_valid_out),
    .sr_addr_out(sr_addr_out), .sr_data_out(sr_data_out), .ref_done(ref_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst === 1'b1) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", {63'd0, rd_valid}, 64'd0);
        else chk("rd_data", rd, rd_q.pop_front());
      end
      if (sr_valid_out) begin
        if (sw_q.size() == 0) chk("sr_unexpected", {63'd0, sr_valid_out}, 64'd0);
        else begin
          mon_e = sw_q.pop_front();
          chk("sr_addr", {57'd0, sr_addr_out}, {57'd0, mon_e.a});
          chk("sr_data", sr_data_out, mon_e.d);
        end
      end
    end

  task automatic idle();
    u_we = 0; u_re = 0; ref_en_in = 0; start_sr = 0;
  endtask

  // mode 0: stray start_sr mid-sweep; mode 1: 3 stalls + write to emitted row 50; mode 2: stop after edge 40
  task automatic sweep(input int mode, output int edges);
    edges = 0;
    start_sr = 1;
    @(posedge clk); #1;
    start_sr = 0;
    chk("busy_start", {63'd0, sr_busy}, 64'd1);
    chk("req_drop", {63'd0, sr_req}, 64'd0);
    while (!ref_done && edges < 400 && !(mode == 2 && edges == 40)) begin
      start_sr = mode == 0 && edges == 50;
      u_re = mode == 1 && edges < 3;
      u_read_addr = 7'd20;
      if (u_re) rd_q.push_back(model[20]);
      u_we = mode == 1 && edges == 53;
      u_write_addr = 7'd50;
      u_data_in = 64'hFFFF;
      @(posedge clk); #1;
      edges++;
      idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle();
    u_write_addr = 0; u_read_addr = 0; ref_addr_in = 0; u_data_in = 0; ref_data_in = 0;
    tv[0]  = '{1'b1, 7'd10, 64'h9,    1'b0, 7'd0,  1'b0, 7'd0,  64'h0,    64'h0};
    tv[1]  = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd10, 1'b0, 7'd0,  64'h0,    64'h9};
    tv[2]  = '{1'b1, 7'd5,  64'h384,  1'b0, 7'd0,  1'b1, 7'd5,  64'h6,    64'h0};
    tv[3]  = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd5,  1'b0, 7'd0,  64'h0,    64'h384};
    tv[4]  = '{1'b1, 7'd3,  64'hA,    1'b0, 7'd0,  1'b1, 7'd4,  64'hB,    64'h0};
    tv[5]  = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd3,  1'b0, 7'd0,  64'h0,    64'hA};
    tv[6]  = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd4,  1'b0, 7'd0,  64'h0,    64'hB};
    tv[7]  = '{1'b1, 7'd7,  64'h77,   1'b1, 7'd7,  1'b0, 7'd0,  64'h0,    64'h77};
    tv[8]  = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd8,  1'b1, 7'd8,  64'h88,   64'h88};
    tv[9]  = '{1'b1, 7'd9,  64'h99,   1'b1, 7'd9,  1'b1, 7'd9,  64'h11,   64'h99};
    tv[10] = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd9,  1'b0, 7'd0,  64'h0,    64'h99};
    tv[11] = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd7,  1'b0, 7'd0,  64'h0,    64'h77};
    tv[12] = '{1'b1, 7'd10, 64'h123,  1'b1, 7'd10, 1'b0, 7'd0,  64'h0,    64'h123};
    tv[13] = '{1'b1, 7'd12, 64'hBEEF, 1'b1, 7'd11, 1'b1, 7'd11, 64'hDEAD, 64'hDEAD};
    tv[14] = '{1'b0, 7'd0,  64'h0,    1'b1, 7'd12, 1'b0, 7'd0,  64'h0,    64'hBEEF};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {59'd0, rd_valid, sr_req, sr_busy, sr_valid_out, ref_done}, 64'd0);
    chk("reset_rd", rd, 64'd0);
    chk("reset_sr_data", sr_data_out, 64'd0);
    rst = 1;
    repeat (14) @(posedge clk);
    #1;
    chk("sr_req_early", {63'd0, sr_req}, 64'd0);
    @(posedge clk); #1;
    chk("sr_req_rise", {63'd0, sr_req}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("sr_req_hold", {63'd0, sr_req}, 64'd1);

    for (int i = 0; i < 15; i++) begin
      u_we = tv[i].we; u_write_addr = tv[i].wa; u_data_in = tv[i].wd;
      u_re = tv[i].re; u_read_addr = tv[i].ra;
      ref_en_in = tv[i].ren; ref_addr_in = tv[i].refa; ref_data_in = tv[i].refd;
      if (tv[i].re) rd_q.push_back(tv[i].exp);
      if (tv[i].we) model[tv[i].wa] = tv[i].wd;
      if (tv[i].ren && !(tv[i].we && tv[i].wa == tv[i].refa)) model[tv[i].refa] = tv[i].refd;
      @(posedge clk); #1;
      idle();
    end
    @(posedge clk); #1;
    chk("rd_valid_low", {63'd0, rd_valid}, 64'd0);
    chk("rd_hold", rd, 64'hBEEF);

    for (int i = 0; i < 128; i++) begin
      u_we = 1; u_write_addr = 7'(i); u_data_in = 64'(i + 1);
      model[i] = 64'(i + 1);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;

    for (int i = 0; i < 128; i++) sw_q.push_back('{7'(i), model[i]});
    sweep(0, n);
    chk("sweep_len", 64'(n), 64'd129);
    chk("sweep_q_empty", 64'(sw_q.size()), 64'd0);
    chk("req_clear_at_done", {63'd0, sr_req}, 64'd0);
    @(posedge clk); #1;
    chk("ref_done_pulse", {62'd0, ref_done, sr_busy}, 64'd0);
    chk("addr_hold", {57'd0, sr_addr_out}, 64'd127);

    model[50] = 64'hFFFF;
    for (int i = 0; i < 128; i++) sw_q.push_back('{7'(i), model[i]});
    sweep(1, n);
    chk("stall_sweep_len", 64'(n), 64'd132);
    chk("stall_q_empty", 64'(sw_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 39; i++) sw_q.push_back('{7'(i), model[i]});
    sweep(2, n);
    rst = 0;
    #1;
    chk("midrst_flags", {59'd0, rd_valid, sr_req, sr_busy, sr_valid_out, ref_done}, 64'd0);
    chk("midrst_addr", {57'd0, sr_addr_out}, 64'd0);
    chk("midrst_data", sr_data_out, 64'd0);
    chk("midrst_q_empty", 64'(sw_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    cnt = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (ref_done || sr_valid_out) cnt++;
    end
    chk("no_done_after_rst", 64'(cnt), 64'd0);

    for (int i = 0; i < 128; i++) begin
      u_re = 1; u_read_addr = 7'(i);
      rd_q.push_back(model[i]);
      @(posedge clk); #1;
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
